// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader: memory geometry,
// loader state encoding and the start-count legality check.
package mips_pkg;

   localparam int IM_ADDR_W = 9;
   localparam int IM_DEPTH  = 512;
   localparam int WC_W      = 10;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_LOAD,
      LD_COMMIT,
      LD_RUN
   } ld_state_t;

   function automatic logic count_ok(input logic [WC_W-1:0] n, input int unsigned depth);
      return (n != '0) && (32'(n) <= depth);
   endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Assembles four accepted bytes, most significant first, into one 32-bit word.
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  cnt_q;
   logic [23:0] part_q;

   // The fourth byte is merged combinationally so the word is ready on its accept edge.
   assign word      = {part_q, byte_data};
   assign word_full = accept && (cnt_q == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         part_q <= '0;
      end else if (clear) begin
         cnt_q  <= '0;
         part_q <= '0;
      end else if (accept) begin
         cnt_q  <= cnt_q + 2'd1;
         part_q <= {part_q[15:0], byte_data};
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a byte-serial program into instruction memory while holding the CPU,
// then releases it with a one-cycle done pulse.
module imem_boot_loader #(
   parameter int IM_ADDR_W = mips_pkg::IM_ADDR_W,
   parameter int IM_DEPTH  = mips_pkg::IM_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [9:0]           word_count,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   output logic                 byte_ready,
   output logic                 im_we,
   output logic [IM_ADDR_W-1:0] im_addr,
   output logic [31:0]          im_data,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   import mips_pkg::*;

   ld_state_t            state_q, state_d;
   logic [9:0]           count_q;
   logic [IM_ADDR_W-1:0] index_q;
   logic                 start_en, start_ok, start_bad;
   logic                 accept, last_word;
   logic                 pk_full;
   logic [31:0]          pk_word;

   assign start_en  = start && ((state_q == LD_IDLE) || (state_q == LD_RUN));
   assign start_ok  = start_en && count_ok(word_count, IM_DEPTH);
   assign start_bad = start_en && !count_ok(word_count, IM_DEPTH);

   assign byte_ready = (state_q == LD_LOAD);
   assign accept     = byte_valid && byte_ready;
   assign im_we      = (state_q == LD_COMMIT);
   assign busy       = (state_q == LD_LOAD) || (state_q == LD_COMMIT);
   assign cpu_hold   = (state_q != LD_RUN);
   assign last_word  = (32'(index_q) + 32'd1) >= 32'(count_q);

   byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .accept    (accept),
      .byte_data (byte_data),
      .word      (pk_word),
      .word_full (pk_full)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         LD_IDLE, LD_RUN: if (start_ok) state_d = LD_LOAD;
         LD_LOAD:         if (pk_full) state_d = LD_COMMIT;
         LD_COMMIT:       state_d = last_word ? LD_RUN : LD_LOAD;
         default:         state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= LD_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         index_q <= '0;
         im_addr <= '0;
         im_data <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= (state_q == LD_COMMIT) && last_word;
         if (start_ok) begin
            count_q <= word_count;
            index_q <= '0;
            err     <= 1'b0;
         end else if (start_bad) begin
            err <= 1'b1;
         end
         // Write address/data are captured once per word so they hold still outside COMMIT.
         if (pk_full) begin
            im_addr <= index_q;
            im_data <= pk_word;
         end
         if ((state_q == LD_COMMIT) && !last_word) index_q <= index_q + IM_ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: directed loads push expected writes,
// a negedge monitor pops and compares every im_we cycle.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        im_we;
   logic [8:0]  im_addr;
   logic [31:0] im_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  tests    = 0;
   int  fails    = 0;
   int  done_cnt = 0;

   imem_boot_loader #(.IM_ADDR_W(9), .IM_DEPTH(512)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_data    (im_data),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", im_addr, im_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(im_addr), 32'(e.addr));
            check("wr_data", im_data, e.data);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         check("done_cpu_hold", 32'(cpu_hold), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [9:0] n);
      start      = 1'b1;
      word_count = n;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic acc;
      acc        = 1'b0;
      byte_data  = b;
      byte_valid = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         acc = byte_ready;
         tick();
      end
      byte_valid = 1'b0;
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL byte_timeout: got byte_ready 0 expected 1 within 100 cycles");
      end
      for (int g = 0; g < gap; g++) tick();
   endtask

   task automatic load_word(input logic [8:0] addr, input logic [31:0] data, input int gap);
      exp_q.push_back('{addr, data});
      for (int k = 0; k < 4; k++) send_byte(data[31-8*k -: 8], gap);
   endtask

   task automatic wait_done(input int budget);
      int prev;
      prev = done_cnt;
      for (int i = 0; i < budget && done_cnt == prev; i++) tick();
      check("done_seen", 32'(done_cnt - prev), 32'd1);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_im_data", im_data, 32'd0);
      check("rst_im_addr", 32'(im_addr), 32'd0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      reset      = 1'b1;
      start      = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (3) tick();
      reset = 1'b0;

      check("init_byte_ready", 32'(byte_ready), 32'd0);
      check("init_im_we", 32'(im_we), 32'd0);
      check("init_im_addr", 32'(im_addr), 32'd0);
      check("init_im_data", im_data, 32'd0);
      check("init_cpu_hold", 32'(cpu_hold), 32'd1);
      check("init_busy", 32'(busy), 32'd0);
      check("init_done", 32'(done), 32'd0);
      check("init_err", 32'(err), 32'd0);

      // single word load
      start_load(10'd1);
      check("single_busy", 32'(busy), 32'd1);
      check("single_hold", 32'(cpu_hold), 32'd1);
      load_word(9'd0, 32'h2008_0005, 0);
      wait_done(20);
      check("single_run_hold", 32'(cpu_hold), 32'd0);
      check("single_run_busy", 32'(busy), 32'd0);

      // three words, byte_valid toggling every other cycle
      start_load(10'd3);
      check("gap_hold", 32'(cpu_hold), 32'd1);
      load_word(9'd0, 32'h1122_3344, 1);
      load_word(9'd1, 32'h5566_7788, 1);
      load_word(9'd2, 32'h99AA_BBCC, 1);
      wait_done(20);

      // illegal counts in IDLE, then a valid start clears err
      apply_reset();
      start_load(10'd0);
      check("cnt0_err", 32'(err), 32'd1);
      check("cnt0_busy", 32'(busy), 32'd0);
      start_load(10'd513);
      check("cnt513_err", 32'(err), 32'd1);
      check("cnt513_ready", 32'(byte_ready), 32'd0);
      check("cnt513_hold", 32'(cpu_hold), 32'd1);
      repeat (3) tick();
      start_load(10'd1);
      check("valid_clears_err", 32'(err), 32'd0);
      load_word(9'd0, 32'hDEAD_BEEF, 0);
      wait_done(20);
      start_load(10'd600);
      check("run_bad_err", 32'(err), 32'd1);
      check("run_bad_hold", 32'(cpu_hold), 32'd0);

      // reset mid-load discards partial bytes
      start_load(10'd1);
      check("reload_err_clear", 32'(err), 32'd0);
      send_byte(8'hEE, 0);
      send_byte(8'hFF, 0);
      apply_reset();
      start_load(10'd1);
      load_word(9'd0, 32'hAABB_CCDD, 0);
      wait_done(20);

      // reload from RUN; start during LOAD ignored
      check("pre_reload_hold", 32'(cpu_hold), 32'd0);
      prev = done_cnt;
      start_load(10'd2);
      check("reload_hold", 32'(cpu_hold), 32'd1);
      exp_q.push_back('{9'd0, 32'h1234_5678});
      send_byte(8'h12, 0);
      start_load(10'd0);
      check("load_start_ignored_err", 32'(err), 32'd0);
      start_load(10'd1);
      check("load_start_ignored_busy", 32'(busy), 32'd1);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      load_word(9'd1, 32'h9ABC_DEF0, 0);
      wait_done(20);
      repeat (3) tick();
      check("reload_done_once", 32'(done_cnt - prev), 32'd1);

      // full depth load
      prev = done_cnt;
      start_load(10'd512);
      for (int w = 0; w < 512; w++) load_word(9'(w), 32'hC0DE_0000 | 32'(w), 0);
      wait_done(20);
      repeat (5) tick();
      check("full_done_once", 32'(done_cnt - prev), 32'd1);
      check("full_last_addr", 32'(im_addr), 32'd511);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter IM_ADDR_W, default 9: instruction-memory address width.
REQ-002 SHALL have parameter IM_DEPTH, default 512: maximum loadable words.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a program load; sampled with word_count.
REQ-006 SHALL have port word_count, input, 10: number of 32-bit words to load.
REQ-007 SHALL have port byte_valid, input, 1: byte_data is valid.
REQ-008 SHALL have port byte_data, input, 8: program byte stream, big-endian within each word.
REQ-009 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-010 SHALL have port im_we, output, 1: instruction-memory write enable.
REQ-011 SHALL have port im_addr, output, IM_ADDR_W: instruction-memory write address.
REQ-012 SHALL have port im_data, output, 32: instruction-memory write data.
REQ-013 SHALL have port cpu_hold, output, 1: holds processor PC at reset while high.
REQ-014 SHALL have port busy, output, 1: high in LOAD and COMMIT.
REQ-015 SHALL have port done, output, 1: one-cycle pulse on load completion.
REQ-016 SHALL have port err, output, 1: sticky illegal-count flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, COMMIT, RUN.
REQ-018 SHALL accept a byte only when byte_valid and byte_ready are both high in the same cycle.
REQ-019 SHALL drive byte_ready high only in LOAD.
REQ-020 SHALL place accepted bytes 0..3 of each word into im_data bits [31:24], [23:16], [15:8], [7:0] respectively.
REQ-021 SHALL enter COMMIT in the cycle after the 4th byte of a word is accepted.
REQ-022 SHALL assert im_we for exactly one cycle in COMMIT, with im_addr equal to the word index and im_data equal to the assembled word.
REQ-023 SHALL, from COMMIT, return to LOAD with index+1 when the index is below word_count-1, otherwise enter RUN.
REQ-024 SHALL set the word index to 0 on each accepted start, so addresses never wrap; the last address is word_count-1.
REQ-025 SHALL, in IDLE or RUN, treat start with word_count in 1..IM_DEPTH as valid: latch the count, clear err, and enter LOAD.
REQ-026 SHALL, on start with word_count of 0 or greater than IM_DEPTH, set err, stay in the current state, and perform no write.
REQ-027 SHALL ignore start in LOAD and COMMIT.
REQ-028 SHALL drive cpu_hold high in IDLE, LOAD and COMMIT, and low only in RUN.
REQ-029 SHALL pulse done in the first RUN cycle, the same cycle cpu_hold first goes low.
REQ-030 SHALL force cpu_hold high from the cycle after an accepted start in RUN (reload).
REQ-031 SHALL hold im_we at 0 and im_addr and im_data stable outside COMMIT.
REQ-032 SHALL tolerate arbitrary gaps in byte_valid without losing or duplicating bytes.

Reset
REQ-033 SHALL, on reset, immediately set state IDLE, byte_ready 0, im_we 0, im_addr 0, im_data 0, cpu_hold 1, busy 0, done 0, err 0, byte counter 0, word index 0.
REQ-034 SHALL discard partially assembled words and the latched count when reset occurs mid-load.

Structure
REQ-035 SHALL take IM_ADDR_W, IM_DEPTH and the loader state enum from the shared package mips_pkg.
REQ-036 SHALL contain one sub-module, byte_packer, holding the 2-bit byte counter and 32-bit shift assembly with a word_full indication.

Verification
REQ-037 SHALL cover: start, word_count=1, bytes 20 08 00 05 -> one im_we, im_addr 0, im_data 0x20080005, done pulse, cpu_hold 1->0.
REQ-038 SHALL cover: word_count=3, byte_valid toggling every other cycle -> writes at addresses 0, 1, 2 in order, then done.
REQ-039 SHALL cover: start with word_count=0, then 513 -> err=1, no im_we, state stays IDLE; a following valid start clears err.
REQ-040 SHALL cover: reset after 2 bytes, then start word_count=1 with bytes AA BB CC DD -> im_data 0xAABBCCDD, no stale bytes.
REQ-041 SHALL cover: start during LOAD is ignored; start in RUN with word_count=2 -> cpu_hold high next cycle, addresses 0 and 1 rewritten.
REQ-042 SHALL cover: word_count=512 -> final write at address 511, no wrap, done once.
